// File: rtl/idft_pkg.sv
// idft_pkg: shared constants, state encoding and saturation helpers for the inverse DFT
package idft_pkg;
  localparam logic signed [31:0] CORDIC_KINV_Q24 = 32'sd10188013;
  localparam logic signed [31:0] QUARTER_PI_Q24  = 32'sd13176795;
  localparam logic signed [31:0] TWO_PI_Q24      = 32'sd105414357;
  localparam logic signed [31:0] ATAN_LUT_Q24 [0:25] = '{
    32'sd13176795, 32'sd7778716, 32'sd4110060, 32'sd2086331, 32'sd1047214,
    32'sd524117,   32'sd262123,  32'sd131069,  32'sd65536,   32'sd32768,
    32'sd16384,    32'sd8192,    32'sd4096,    32'sd2048,    32'sd1024,
    32'sd512,      32'sd256,     32'sd128,     32'sd64,      32'sd32,
    32'sd16,       32'sd8,       32'sd4,       32'sd2,       32'sd1,
    32'sd0
  };
  typedef enum logic [1:0] {ST_LOAD, ST_TERM, ST_CORDIC, ST_EMIT} state_t;
  function automatic logic signed [31:0] neg_sat(input logic signed [31:0] v);
    return (v == 32'sh80000000) ? 32'sh7fffffff : -v;
  endfunction
  function automatic logic signed [31:0] sat32(input logic signed [35:0] v);
    return (&v[35:31] || ~|v[35:31]) ? v[31:0] : (v[35] ? 32'sh80000000 : 32'sh7fffffff);
  endfunction
endpackage

// File: rtl/idft_cordic_seq_cordic.sv
// cordic_rotate_iter: iterative rotation-mode CORDIC with gain compensation applied up front
module cordic_rotate_iter import idft_pkg::*; #(
  parameter int ITER = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               start,
  input  logic signed [31:0] x_in,
  input  logic signed [31:0] y_in,
  input  logic signed [31:0] z_in,
  output logic               done,
  output logic signed [31:0] x_out,
  output logic signed [31:0] y_out
);
  localparam int CW = $clog2(ITER + 1);
  logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d, atan;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d, done_q, done_d, last;
  assign atan  = ATAN_LUT_Q24[cnt_q];
  assign last  = cnt_q == CW'(ITER - 1);
  assign done  = done_q;
  assign x_out = x_q;
  assign y_out = y_q;
  // start loads Kinv-scaled operands; each later enabled cycle performs one micro-rotation
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    cnt_d = cnt_q;
    run_d = run_q;
    done_d = done_q;
    if (enable) begin
      done_d = run_q && last;
      if (start) begin
        x_d = 32'((64'(x_in) * 64'(CORDIC_KINV_Q24)) >>> 24);
        y_d = 32'((64'(y_in) * 64'(CORDIC_KINV_Q24)) >>> 24);
        z_d = z_in;
        cnt_d = '0;
        run_d = 1'b1;
      end else if (run_q) begin
        x_d = z_q[31] ? x_q + (y_q >>> cnt_q) : x_q - (y_q >>> cnt_q);
        y_d = z_q[31] ? y_q - (x_q >>> cnt_q) : y_q + (x_q >>> cnt_q);
        z_d = z_q[31] ? z_q + atan : z_q - atan;
        cnt_d = cnt_q + CW'(1);
        run_d = !last;
      end
    end
  end
  // iteration state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      done_q <= done_d;
    end
  end
endmodule

// File: rtl/idft_cordic_seq.sv
// idft_cordic_seq: 8-point inverse DFT time-multiplexing one iterative CORDIC over all terms
module idft_cordic_seq import idft_pkg::*; #(
  parameter int N    = 8,
  parameter int ITER = 24,
  parameter int W    = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [2:0]   out_index,
  output logic         out_last,
  output logic         busy
);
  state_t state_q, state_d;
  logic [W-1:0] bin_re_q [N];
  logic [W-1:0] bin_im_q [N];
  logic [2:0] k_q, k_d, n_q, n_d, m;
  logic signed [35:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d, sum_re, sum_im;
  logic signed [W-1:0] b_re, b_im, pr_re, pr_im, c_re, c_im, add_re, add_im;
  logic signed [W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic in_fire, out_fire, acc_fire, c_done;
  assign m = k_q * n_q;
  assign b_re = bin_re_q[k_q];
  assign b_im = bin_im_q[k_q];
  assign pr_re = (m[2:1] == 2'd0) ? b_re : (m[2:1] == 2'd1) ? neg_sat(b_im) : (m[2:1] == 2'd2) ? neg_sat(b_re) : b_im;
  assign pr_im = (m[2:1] == 2'd0) ? b_im : (m[2:1] == 2'd1) ? b_re : (m[2:1] == 2'd2) ? neg_sat(b_im) : neg_sat(b_re);
  assign add_re = (state_q == ST_CORDIC) ? c_re : pr_re;
  assign add_im = (state_q == ST_CORDIC) ? c_im : pr_im;
  assign sum_re = acc_re_q + 36'(add_re);
  assign sum_im = acc_im_q + 36'(add_im);
  // handshakes are gated by enable so a frozen block never completes a transfer
  assign in_ready  = enable && state_q == ST_LOAD;
  assign out_valid = enable && state_q == ST_EMIT;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign acc_fire  = enable && ((state_q == ST_TERM && !m[0]) || (state_q == ST_CORDIC && c_done));
  assign busy      = state_q != ST_LOAD;
  assign out_index = n_q;
  assign out_last  = state_q == ST_EMIT && n_q == 3'd7;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  cordic_rotate_iter #(.ITER(ITER)) u_cordic (
    .clk   (clock),
    .rst_n (reset),
    .enable(enable),
    .start (state_q == ST_TERM && m[0]),
    .x_in  (pr_re),
    .y_in  (pr_im),
    .z_in  (QUARTER_PI_Q24),
    .done  (c_done),
    .x_out (c_re),
    .y_out (c_im)
  );
  // sequencing: load bins, walk k per sample (even m direct, odd m via CORDIC), emit, next n
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    n_d = n_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    if (in_fire) begin
      k_d = k_q + 3'd1;
      state_d = (k_q == 3'd7) ? ST_TERM : ST_LOAD;
    end
    if (acc_fire) begin
      acc_re_d = sum_re;
      acc_im_d = sum_im;
      k_d = k_q + 3'd1;
      state_d = (k_q == 3'd7) ? ST_EMIT : ST_TERM;
      out_re_d = (k_q == 3'd7) ? sat32(sum_re >>> 3) : out_re_q;
      out_im_d = (k_q == 3'd7) ? sat32(sum_im >>> 3) : out_im_q;
    end else if (enable && state_q == ST_TERM) begin
      state_d = ST_CORDIC;
    end
    if (out_fire) begin
      acc_re_d = '0;
      acc_im_d = '0;
      k_d = 3'd0;
      n_d = n_q + 3'd1;
      state_d = (n_q == 3'd7) ? ST_LOAD : ST_TERM;
    end
  end
  // state, accumulator, output and bin register file
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      k_q <= '0;
      n_q <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
      for (int i = 0; i < N; i++) begin
        bin_re_q[i] <= '0;
        bin_im_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      n_q <= n_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
      if (in_fire) begin
        bin_re_q[k_q] <= in_re;
        bin_im_q[k_q] <= in_im;
      end
    end
  end
endmodule
